if_id_queue: RTL
================

Name: if_id_queue

Overview:
Parametrised successor to the single-register IF/ID stage. It decouples fetch from decode with a DEPTH-entry instruction queue, so fetched instructions are buffered during decode stalls instead of being re-fetched. An empty queue bypasses straight to the output register, giving the classic 1-cycle IF->ID latency. It sits between the PC/instruction-memory stage and the ID stage, and is driven by the global stall vector and the exception flush.

Parameters:
AW, 32, PC width
IW, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2
STALL_W, 6, width of the global stall vector
ID_BIT, 2, index of the stall bit that freezes ID

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush (exception/eret)
stall  in  STALL_W  global stall vector; only stall[ID_BIT] is used
if_valid  in  1  fetch presents a valid pc/inst this cycle
if_pc  in  AW  fetched PC
if_inst  in  IW  fetched instruction
if_ready  out  1  queue can accept a push this cycle
stall_req  out  1  request to the controller to freeze PC; equals ~if_ready
id_pc  out  AW  registered PC to ID
id_inst  out  IW  registered instruction to ID
id_valid  out  1  id_pc/id_inst hold a real instruction
count  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising clk edge.
- Reset: id_pc=0, id_inst=0, id_valid=0, count=0, head and tail pointers=0. if_ready=1 after reset.
- Priority, highest first: rst > flush > normal operation.
- flush=1:
  - Same effect as reset on outputs, pointers and count.
  - Any push offered in that cycle is dropped.
- if_ready = (count != DEPTH). Combinational from registered count only; there is no pop-to-push bypass when full.
- push = if_valid & if_ready.
- adv = ~stall[ID_BIT] (ID consumes this cycle).
- adv=0:
  - id_pc, id_inst and id_valid hold their values.
  - A push writes the tail entry; tail++ and count++.
- adv=1, count>0:
  - Output registers load the head entry and id_valid=1; head++.
  - A simultaneous push writes the tail, tail++ and count is unchanged.
  - With no push, count--.
- adv=1, count=0, push=1 (bypass): output registers load if_pc/if_inst and id_valid=1. The queue is not written. Latency is 1 cycle.
- adv=1, count=0, push=0 (bubble): id_pc=0, id_inst=0, id_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Entries leave in strict FIFO order.
- Full (count=DEPTH): if_ready=0 and stall_req=1. Fetch must hold if_pc/if_inst. A pop in that cycle does not admit a push.
- An unaccepted if_valid (if_ready=0) has no effect.
- count never exceeds DEPTH and never underflows.
- Storage contents are not reset; only pointers and count are.

Decomposition:
- Shared defines file (existing My_defines.v): Enable, Zero, and new stall-bit indices STALL_IF=1 and STALL_ID=2. The ID_BIT default comes from STALL_ID.
- One sub-module, inst_fifo (AW+IW wide, DEPTH entries). It owns the storage, head/tail pointers and count, and exposes push/pop/full/empty/rdata.
- if_id_queue owns the bypass/bubble decision, the output registers and flush/reset sequencing.

Test Plan:
- Reset then free-run: no stall, if_valid every cycle with PC 0x00,0x04,0x08. id_pc follows one cycle later. count stays 0 and id_valid=1 from the first push.
- Decode stall: assert stall[2] for 3 cycles while pushing 0x10,0x14,0x18. id_pc holds and count rises to 3. On release, id_pc shows 0x10,0x14,0x18 on successive cycles, then bypass resumes.
- Full: stall[2]=1 for 6 cycles with DEPTH=4. count saturates at 4, and if_ready=0 and stall_req=1 from the 5th cycle. The 5th instruction is accepted only after the first pop.
- Bubble: if_valid=0 with stall[2]=0 and an empty queue. id_inst=0, id_pc=0, id_valid=0.
- Flush mid-queue: count=3 and flush=1 together with a push of 0x40. Next cycle count=0, id_pc=0, id_valid=0. 0x40 is never delivered.
- Wrap-around: stream 12 instructions with stall[2] toggling every 2 cycles (DEPTH=4). All 12 PCs emerge in order with no loss or duplication.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: stall-vector bit indices
// and the output-register source selection.
package if_id_queue_pkg;

  localparam logic ENABLE = 1'b1;
  localparam logic ZERO   = 1'b0;

  localparam int unsigned STALL_IF = 1;
  localparam int unsigned STALL_ID = 2;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_HEAD   = 2'd1,
    SEL_BYPASS = 2'd2,
    SEL_BUBBLE = 2'd3
  } out_sel_e;

endpackage

// File: rtl/if_id_queue_inst_fifo.sv
// Circular instruction buffer: storage, head/tail pointers and occupancy count.
// Pointer/count state is reset; storage contents are not.
module inst_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign rdata     = mem_q[head_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_ok_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[tail_q] <= wdata;
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID stage with a DEPTH-entry instruction queue; an empty queue bypasses
// the fetched instruction straight into the ID output registers.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int AW      = 32,
  parameter int IW      = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 6,
  parameter int ID_BIT  = STALL_ID,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               if_valid,
  input  logic [AW-1:0]      if_pc,
  input  logic [IW-1:0]      if_inst,
  output logic               if_ready,
  output logic               stall_req,
  output logic [AW-1:0]      id_pc,
  output logic [IW-1:0]      id_inst,
  output logic               id_valid,
  output logic [CW-1:0]      count
);

  logic [AW-1:0]    id_pc_q, id_pc_d;
  logic [IW-1:0]    id_inst_q, id_inst_d;
  logic             id_valid_q, id_valid_d;
  logic             adv_s;
  logic             push_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [AW+IW-1:0] fifo_rdata_s;
  out_sel_e         sel_s;

  assign adv_s     = ~stall[ID_BIT];
  assign if_ready  = ~fifo_full_s;
  assign stall_req = fifo_full_s;
  assign push_s    = if_valid & if_ready;
  // A push into an empty queue that ID consumes now goes straight to the output.
  assign fifo_push_s = push_s & ~(adv_s & fifo_empty_s);
  assign fifo_pop_s  = adv_s & ~fifo_empty_s;

  inst_fifo #(
    .W     (AW + IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata ({if_pc, if_inst}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count)
  );

  always_comb begin
    sel_s = SEL_HOLD;
    if (!adv_s) begin
      sel_s = SEL_HOLD;
    end else if (!fifo_empty_s) begin
      sel_s = SEL_HEAD;
    end else if (push_s) begin
      sel_s = SEL_BYPASS;
    end else begin
      sel_s = SEL_BUBBLE;
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    case (sel_s)
      SEL_HEAD: begin
        id_pc_d    = fifo_rdata_s[AW+IW-1:IW];
        id_inst_d  = fifo_rdata_s[IW-1:0];
        id_valid_d = ENABLE;
      end
      SEL_BYPASS: begin
        id_pc_d    = if_pc;
        id_inst_d  = if_inst;
        id_valid_d = ENABLE;
      end
      SEL_BUBBLE: begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = ZERO;
      end
      default: begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= ZERO;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule
